cdc_reg_responder: RTL

//  Application-side responder on one usb_cdc channel: parses ASCII register commands from the host
//  (OUT stream) and returns ASCII replies (IN stream). Gives host software byte-register access to

---
 rtl/cdc_reg_responder_pkg.sv | 53 +++++
 rtl/cdc_reg_responder_if.sv | 25 ++
 rtl/cdc_reply_tx.sv | 89 ++++++++
 rtl/cdc_reg_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cdc_reg_responder_pkg.sv
// rtl/cdc_reg_responder_pkg.sv - ASCII constants, parser states and hex helpers for cdc_reg_responder
package cdc_reg_responder_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_WAIT_CR,
    ST_FLUSH,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  // Decodes one ASCII hex digit (either case); valid=0 for anything else.
  function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r.nib = c[3:0] + 4'd9;
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  // Encodes a nibble as an uppercase ASCII hex digit.
  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Case-insensitive match of a letter byte against its uppercase form.
  function automatic logic is_letter(input logic [7:0] c, input logic [7:0] upper);
    return (c == upper) || (c == (upper | 8'h20));
  endfunction

endpackage

// File: rtl/cdc_reg_responder_if.sv
// rtl/cdc_reg_responder_if.sv - host OUT stream and reply IN stream bundle for cdc_reg_responder
interface cdc_reg_responder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  // usb_cdc side: produces host bytes, consumes reply bytes
  modport master (
    output out_data, out_valid,
    input  out_ready,
    input  in_data, in_valid,
    output in_ready
  );

  // responder side
  modport slave (
    input  out_data, out_valid,
    output out_ready,
    output in_data, in_valid,
    input  in_ready
  );
endinterface

// File: rtl/cdc_reply_tx.sv
// rtl/cdc_reply_tx.sv - 4-byte reply serializer with one-byte echo slot (echo used with CDC_REG_RESPONDER_ECHO_EN)
module cdc_reply_tx
  import cdc_reg_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       reply_load,
  input  logic [7:0] reply_c0,
  input  logic [7:0] reply_c1,
  input  logic       echo_load,
  input  logic [7:0] echo_byte,
  input  logic       in_ready,
  output logic [7:0] in_data,
  output logic       in_valid,
  output logic       echo_busy,
  output logic       reply_done
);

  logic       echo_vld_q;
  logic [7:0] echo_q;
  logic       rep_vld_q;
  logic [1:0] cnt_q;
  logic [7:0] c0_q;
  logic [7:0] c1_q;
  logic [7:0] rep_byte;
  logic       fire;
  logic       rep_fire;

  // Every reply is two payload characters followed by CR LF.
  always_comb begin
    rep_byte = 8'h00;
    unique case (cnt_q)
      2'd0:    rep_byte = c0_q;
      2'd1:    rep_byte = c1_q;
      2'd2:    rep_byte = ASCII_CR;
      default: rep_byte = ASCII_LF;
    endcase
  end

  assign in_valid   = echo_vld_q | rep_vld_q;
  assign fire       = in_valid & in_ready;
  assign rep_fire   = fire & ~echo_vld_q & rep_vld_q;
  assign reply_done = rep_fire & (cnt_q == 2'd3);
  assign echo_busy  = echo_vld_q;

  // Echo byte always goes out before any reply byte loaded in the same cycle.
  always_comb begin
    in_data = 8'h00;
    if (echo_vld_q) begin
      in_data = echo_q;
    end else if (rep_vld_q) begin
      in_data = rep_byte;
    end
  end

  // Echo slot: filled on host byte acceptance, emptied when the sink takes it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      echo_vld_q <= 1'b0;
      echo_q     <= 8'h00;
    end else if (echo_load) begin
      echo_vld_q <= 1'b1;
      echo_q     <= echo_byte;
    end else if (fire && echo_vld_q) begin
      echo_vld_q <= 1'b0;
    end
  end

  // Reply shifter: captures the two payload characters and walks the byte index.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rep_vld_q <= 1'b0;
      cnt_q     <= 2'd0;
      c0_q      <= 8'h00;
      c1_q      <= 8'h00;
    end else if (reply_load) begin
      rep_vld_q <= 1'b1;
      cnt_q     <= 2'd0;
      c0_q      <= reply_c0;
      c1_q      <= reply_c1;
    end else if (rep_fire) begin
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        rep_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cdc_reg_responder.sv
// rtl/cdc_reg_responder.sv - ASCII register command parser and register file; echo via CDC_REG_RESPONDER_ECHO_EN
module cdc_reg_responder
  import cdc_reg_responder_pkg::*;
#(
  parameter int         REGS      = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  cdc_reg_responder_if.slave   host,
  output logic [8*REGS-1:0]    regs_o
);

  localparam logic [8:0] REGS_LIM = 9'(REGS);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] regs_q [REGS];
  logic       is_wr_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       ready_q;

  logic       host_acc;
  logic [7:0] rx_byte;
  hex_nib_t   rx_hex;
  logic       rx_cr;
  logic       rx_lf;
  logic       rx_rd;
  logic       rx_wr;

  logic       cmd_ok;
  logic       addr_ok;
  logic       cr_fire;
  logic       wr_en;
  logic       reply_load;
  logic [7:0] reply_c0;
  logic [7:0] reply_c1;
  logic [7:0] rd_val;

  logic       echo_load;
  logic [7:0] echo_byte;
  logic       echo_busy;
  logic       reply_done;
  logic [7:0] tx_data;
  logic       tx_valid;

  assign rx_byte  = host.out_data;
  assign host_acc = host.out_valid & host.out_ready;
  assign rx_hex   = hex_to_nib(rx_byte);
  assign rx_cr    = (rx_byte == ASCII_CR);
  assign rx_lf    = (rx_byte == ASCII_LF);
  assign rx_rd    = is_letter(rx_byte, ASCII_R);
  assign rx_wr    = is_letter(rx_byte, ASCII_W);

  // Host side stalls during a reply and while an echoed byte is still in flight.
  assign host.out_ready = ready_q & ~echo_busy;

`ifdef CDC_REG_RESPONDER_ECHO_EN
  assign echo_load = host_acc;
  assign echo_byte = rx_byte;
`else
  assign echo_load = 1'b0;
  assign echo_byte = 8'h00;
`endif

  // Parser state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parser next state: any off-grammar byte drops into FLUSH; a CR that ends a
  // truncated command goes straight to an error reply.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_acc) begin
          if (rx_rd || rx_wr)      state_d = ST_ADDR_H;
          else if (rx_cr || rx_lf) state_d = ST_IDLE;
          else                     state_d = ST_FLUSH;
        end
      end
      ST_ADDR_H: begin
        if (host_acc) begin
          if (rx_hex.valid) state_d = ST_ADDR_L;
          else if (rx_cr)   state_d = ST_RESP;
          else              state_d = ST_FLUSH;
        end
      end
      ST_ADDR_L: begin
        if (host_acc) begin
          if (rx_hex.valid) state_d = is_wr_q ? ST_DATA_H : ST_WAIT_CR;
          else if (rx_cr)   state_d = ST_RESP;
          else              state_d = ST_FLUSH;
        end
      end
      ST_DATA_H: begin
        if (host_acc) begin
          if (rx_hex.valid) state_d = ST_DATA_L;
          else if (rx_cr)   state_d = ST_RESP;
          else              state_d = ST_FLUSH;
        end
      end
      ST_DATA_L: begin
        if (host_acc) begin
          if (rx_hex.valid) state_d = ST_WAIT_CR;
          else if (rx_cr)   state_d = ST_RESP;
          else              state_d = ST_FLUSH;
        end
      end
      ST_WAIT_CR: begin
        if (host_acc) state_d = rx_cr ? ST_RESP : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (host_acc && rx_cr) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (reply_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux over the register file; out-of-range addresses are never replied with data.
  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < REGS; k++) begin
      if (addr_q == k[7:0]) rd_val = regs_q[k];
    end
  end

  // Parser outputs: at the terminating CR decide write commit and reply text.
  always_comb begin
    cmd_ok     = (state_q == ST_WAIT_CR);
    addr_ok    = ({1'b0, addr_q} < REGS_LIM);
    cr_fire    = host_acc && rx_cr && (state_q != ST_IDLE) && (state_q != ST_RESP);
    reply_load = cr_fire;
    wr_en      = cr_fire && cmd_ok && addr_ok && is_wr_q;
    reply_c0   = ASCII_E;
    reply_c1   = ASCII_R;
    if (cmd_ok && addr_ok) begin
      if (is_wr_q) begin
        reply_c0 = ASCII_O;
        reply_c1 = ASCII_K;
      end else begin
        reply_c0 = nib_to_hex(rd_val[7:4]);
        reply_c1 = nib_to_hex(rd_val[3:0]);
      end
    end
  end

  // Command fields captured nibble by nibble; ready is registered so it is low in reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      is_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_d != ST_RESP);
      if (host_acc) begin
        unique case (state_q)
          ST_IDLE:   is_wr_q     <= rx_wr;
          ST_ADDR_H: addr_q[7:4] <= rx_hex.nib;
          ST_ADDR_L: addr_q[3:0] <= rx_hex.nib;
          ST_DATA_H: data_q[7:4] <= rx_hex.nib;
          ST_DATA_L: data_q[3:0] <= rx_hex.nib;
          default: ;
        endcase
      end
    end
  end

  // Register file; a write lands on the CR acceptance edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < REGS; k++) regs_q[k] <= RESET_VAL;
    end else if (wr_en) begin
      for (int k = 0; k < REGS; k++) begin
        if (addr_q == k[7:0]) regs_q[k] <= data_q;
      end
    end
  end

  for (genvar g = 0; g < REGS; g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  cdc_reply_tx u_tx (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .reply_load (reply_load),
    .reply_c0   (reply_c0),
    .reply_c1   (reply_c1),
    .echo_load  (echo_load),
    .echo_byte  (echo_byte),
    .in_ready   (host.in_ready),
    .in_data    (tx_data),
    .in_valid   (tx_valid),
    .echo_busy  (echo_busy),
    .reply_done (reply_done)
  );

  assign host.in_data  = tx_data;
  assign host.in_valid = tx_valid;

endmodule
